// File: rtl/music_addr_ctrl_if.sv
// ---------------------------------------------------------------------------
// music_addr_ctrl_if
// Avalon-MM read-only bus between the song address controller and the flash.
//   flash_mem_read          master -> slave  read request
//   flash_mem_address       master -> slave  word address (ADDR_W bits)
//   flash_mem_byteenable    master -> slave  byte enables (always all ones)
//   flash_mem_waitrequest   slave -> master  stall, request must be held
//   flash_mem_readdata      slave -> master  {sample_hi[15:0], sample_lo[15:0]}
//   flash_mem_readdatavalid slave -> master  readdata valid this cycle
// ---------------------------------------------------------------------------
interface music_addr_ctrl_if #(
  parameter int ADDR_W = 23
) ();
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/music_addr_ctrl.sv
// ---------------------------------------------------------------------------
// music_addr_ctrl
// Walks a song stored in flash one 32-bit word at a time and hands one 8-bit
// sample (upper byte of a 16-bit sample) to the audio path per sample tick.
// Each word carries two samples; the word is fetched on the first tick and
// the second sample is served from a latch on the next tick, after which the
// address steps forward or backward with wrap-around at both song ends.
// Ports:
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_sample_tick   one-cycle pulse at the audio sample rate
//   i_increment     1 = forward, 0 = backward
//   i_pause         1 = ignore sample ticks
//   i_restart       level; return to ADDR_FIRST (deferred while a read is open)
//   flash           Avalon-MM read master (music_addr_ctrl_if.master)
//   o_audio_data    current 8-bit sample, held between pulses
//   o_audio_valid   one-cycle pulse when o_audio_data is updated
// ---------------------------------------------------------------------------
module music_addr_ctrl #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] ADDR_FIRST = 23'h0,
  parameter logic [ADDR_W-1:0] ADDR_LAST  = 23'h7FFFF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sample_tick,
  input  logic                     i_increment,
  input  logic                     i_pause,
  input  logic                     i_restart,
  music_addr_ctrl_if.master        flash,
  output logic [7:0]               o_audio_data,
  output logic                     o_audio_valid
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_half_pending;
  logic              w_half_nxt;
  logic              r_restart_pending;
  logic              w_restart_nxt;
  logic [7:0]        r_second;       // second sample of the latched word
  logic [7:0]        w_second_nxt;
  logic [7:0]        r_audio;
  logic [7:0]        w_audio_nxt;
  logic              r_audio_valid;
  logic              w_audio_valid_nxt;
  logic              r_read;

  // Neighbouring word address with wrap at both ends of the song.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                   input logic              fwd);
    logic [ADDR_W-1:0] n;
    if (fwd) begin
      if (a == ADDR_LAST) n = ADDR_FIRST;
      else                n = a + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      if (a == ADDR_FIRST) n = ADDR_LAST;
      else                 n = a - {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and next-datapath logic; restart always beats a tick.
  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_half_nxt        = r_half_pending;
    w_restart_nxt     = r_restart_pending;
    w_second_nxt      = r_second;
    w_audio_nxt       = r_audio;
    w_audio_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_restart) begin
          w_addr_nxt = ADDR_FIRST;
          w_half_nxt = 1'b0;
        end else if (i_sample_tick && !i_pause) begin
          if (r_half_pending) begin
            // Serve the latched half, then move on using the current direction.
            w_audio_nxt       = r_second;
            w_audio_valid_nxt = 1'b1;
            w_half_nxt        = 1'b0;
            w_addr_nxt        = step_addr(r_addr, i_increment);
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // The request must stay up while stalled, so restart is only remembered.
        if (i_restart) w_restart_nxt = 1'b1;
        else           w_restart_nxt = r_restart_pending;
        if (!flash.flash_mem_waitrequest) w_state_nxt = ST_WAIT_DATA;
        else                              w_state_nxt = ST_FETCH;
      end
      ST_WAIT_DATA: begin
        if (i_restart) w_restart_nxt = 1'b1;
        else           w_restart_nxt = r_restart_pending;
        if (flash.flash_mem_readdatavalid) begin
          w_state_nxt = ST_IDLE;
          if (r_restart_pending || i_restart) begin
            // Word arrived for an abandoned position: drop it silently.
            w_addr_nxt    = ADDR_FIRST;
            w_half_nxt    = 1'b0;
            w_restart_nxt = 1'b0;
          end else begin
            // Direction at arrival fixes the order of both halves of this word.
            if (i_increment) begin
              w_audio_nxt  = flash.flash_mem_readdata[15:8];
              w_second_nxt = flash.flash_mem_readdata[31:24];
            end else begin
              w_audio_nxt  = flash.flash_mem_readdata[31:24];
              w_second_nxt = flash.flash_mem_readdata[15:8];
            end
            w_audio_valid_nxt = 1'b1;
            w_half_nxt        = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT_DATA;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered bus/audio outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr            <= ADDR_FIRST;
      r_half_pending    <= 1'b0;
      r_restart_pending <= 1'b0;
      r_second          <= 8'h00;
      r_audio           <= 8'h00;
      r_audio_valid     <= 1'b0;
      r_read            <= 1'b0;
    end else begin
      r_addr            <= w_addr_nxt;
      r_half_pending    <= w_half_nxt;
      r_restart_pending <= w_restart_nxt;
      r_second          <= w_second_nxt;
      r_audio           <= w_audio_nxt;
      r_audio_valid     <= w_audio_valid_nxt;
      r_read            <= (w_state_nxt == ST_FETCH);
    end
  end

  assign flash.flash_mem_read       = r_read;
  assign flash.flash_mem_address    = r_addr;
  assign flash.flash_mem_byteenable = 4'hF;
  assign o_audio_data               = r_audio;
  assign o_audio_valid              = r_audio_valid;

endmodule

// File: tb/tb_music_addr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_music_addr_ctrl
// Scoreboard bench: a behavioural model pushes expected read addresses and
// expected audio bytes when a tick is driven; the flash slave model pops the
// address queue on each accepted read, and the audio monitor pops the audio
// queue on each o_audio_valid pulse.
// ---------------------------------------------------------------------------
module tb_music_addr_ctrl;
  localparam int          ADDR_W  = 23;
  localparam logic [22:0] A_FIRST = 23'h0;
  localparam logic [22:0] A_LAST  = 23'h7FFFF;

  logic       clk = 1'b0;
  logic       reset, tick, inc, pause, restart;
  logic [7:0] audio;
  logic       avalid;

  music_addr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  music_addr_ctrl #(.ADDR_W(ADDR_W), .ADDR_FIRST(A_FIRST), .ADDR_LAST(A_LAST)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_sample_tick(tick),
    .i_increment  (inc),
    .i_pause      (pause),
    .i_restart    (restart),
    .flash        (bus),
    .o_audio_data (audio),
    .o_audio_valid(avalid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int valid_cnt = 0, exp_pushes = 0;
  logic [22:0] exp_addr[$];
  logic [7:0]  exp_audio[$];

  // Behavioural model state
  logic [22:0] m_addr = A_FIRST;
  logic        m_half = 1'b0;
  logic        m_fwd  = 1'b1;
  logic [31:0] m_word = 32'h0;

  // Slave configuration and bookkeeping
  int stall_cfg = 0, lat_cfg = 2, stall_left = 0, lat_cnt = 0;
  int rd_len = 0, last_rd_len = 0, acc_cnt = 0;
  logic [22:0] lat_addr = 23'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'd0 || a == 23'd5) return 32'hA1B2_C3D4;
    return {a[7:0] ^ 8'h3C, 8'h11, a[7:0] ^ 8'hE7, 8'h22};
  endfunction

  function automatic logic [22:0] model_next(input logic [22:0] a, input logic fwd);
    if (fwd) return (a == A_LAST) ? A_FIRST : a + 23'd1;
    return (a == A_FIRST) ? A_LAST : a - 23'd1;
  endfunction

  // Flash slave: programmable stall, fixed read latency, address scoreboard.
  initial begin
    bus.flash_mem_waitrequest   = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = mem_word(lat_addr);
        end
      end
      if (bus.flash_mem_read === 1'b1) begin
        rd_len++;
        if (rd_len == 1) stall_left = stall_cfg;
        if (stall_left > 0) begin
          stall_left--;
          bus.flash_mem_waitrequest = 1'b1;
        end else begin
          bus.flash_mem_waitrequest = 1'b0;
          acc_cnt++;
          if (exp_addr.size() == 0)
            check_val("unexpected_read", {31'b0, bus.flash_mem_read}, 32'd0);
          else
            check_val("read_addr", {9'h0, bus.flash_mem_address}, {9'h0, exp_addr.pop_front()});
          check_val("byteenable", {28'h0, bus.flash_mem_byteenable}, 32'hF);
          lat_cnt     = lat_cfg;
          lat_addr    = bus.flash_mem_address;
          last_rd_len = rd_len;
          rd_len      = 0;
        end
      end else begin
        bus.flash_mem_waitrequest = 1'b0;
        rd_len = 0;
      end
    end
  end

  // Audio monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (avalid === 1'b1) begin
      valid_cnt++;
      if (exp_audio.size() == 0)
        check_val("spurious_audio_valid", {31'b0, avalid}, 32'd0);
      else
        check_val("audio_data", {24'h0, audio}, {24'h0, exp_audio.pop_front()});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int start);
    int n = 0;
    while (valid_cnt == start && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check_val(tag, valid_cnt - start, 32'd1);
  endtask

  // Model one accepted tick, drive it, optionally add ticks that must be dropped.
  task automatic play_tick(input string tag, input int extra, input bit pause_after);
    int start;
    if (!m_half) begin
      exp_addr.push_back(m_addr);
      m_word = mem_word(m_addr);
      m_fwd  = inc;
      exp_audio.push_back(m_fwd ? m_word[15:8] : m_word[31:24]);
      m_half = 1'b1;
    end else begin
      exp_audio.push_back(m_fwd ? m_word[31:24] : m_word[15:8]);
      m_half = 1'b0;
      m_addr = model_next(m_addr, inc);
    end
    exp_pushes++;
    start = valid_cnt;
    pulse_tick();
    if (pause_after) pause = 1'b1;
    for (int i = 0; i < extra; i++) pulse_tick();
    wait_valid(tag, start);
    idle(4);
    check_val({tag, "_single"}, valid_cnt - start, 32'd1);
    pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int v0, a0;
    reset = 1'b1; tick = 1'b0; inc = 1'b1; pause = 1'b0; restart = 1'b0;
    idle(3);
    check_val("rst_audio", {24'h0, audio}, 32'h0);
    check_val("rst_valid", {31'b0, avalid}, 32'h0);
    check_val("rst_read", {31'b0, bus.flash_mem_read}, 32'h0);
    check_val("rst_addr", {9'h0, bus.flash_mem_address}, {9'h0, A_FIRST});
    reset = 1'b0;
    idle(2);

    // 1: forward word at address 0
    play_tick("t1_lo", 0, 1'b0);
    check_val("t1_first_c3", {24'h0, audio}, 32'hC3);
    play_tick("t1_hi", 0, 1'b0);
    check_val("t1_second_a1", {24'h0, audio}, 32'hA1);

    // 2: forward to address 5, then backward word there
    for (int i = 0; i < 8; i++) play_tick("t2_walk", 0, 1'b0);
    inc = 1'b0;
    play_tick("t2_bk_hi", 0, 1'b0);
    check_val("t2_first_a1", {24'h0, audio}, 32'hA1);
    play_tick("t2_bk_lo", 0, 1'b0);
    check_val("t2_second_c3", {24'h0, audio}, 32'hC3);

    // 3: restart in IDLE, backward wrap to LAST, forward wrap to FIRST
    pulse_restart();
    m_addr = A_FIRST; m_half = 1'b0;
    idle(2);
    play_tick("t3_bk0_a", 0, 1'b0);
    play_tick("t3_bk0_b", 0, 1'b0);
    inc = 1'b1;
    play_tick("t3_last_a", 0, 1'b0);
    play_tick("t3_last_b", 0, 1'b0);
    play_tick("t3_first_a", 0, 1'b0);
    play_tick("t3_first_b", 0, 1'b0);
    // direction change between halves: order kept, step uses new direction
    play_tick("t3_mix_a", 0, 1'b0);
    inc = 1'b0;
    play_tick("t3_mix_b", 0, 1'b0);
    inc = 1'b1;
    for (int i = 0; i < 4; i++) play_tick("t3_walk", 0, 1'b0);

    // 4: stalled read with restart during FETCH
    stall_cfg = 5;
    exp_addr.push_back(m_addr);
    v0 = valid_cnt;
    pulse_tick();
    idle(1);
    pulse_restart();
    idle(20);
    check_val("t4_read_held", last_rd_len, 32'd6);
    check_val("t4_no_valid", valid_cnt - v0, 32'd0);
    m_addr = A_FIRST; m_half = 1'b0;
    stall_cfg = 0;
    play_tick("t4_after_a", 0, 1'b0);
    play_tick("t4_after_b", 0, 1'b0);

    // restart with a half pending, and restart coinciding with a tick
    play_tick("rs_half", 0, 1'b0);
    pulse_restart();
    m_addr = A_FIRST; m_half = 1'b0;
    play_tick("rs_a", 0, 1'b0);
    v0 = valid_cnt;
    @(negedge clk); restart = 1'b1; tick = 1'b1;
    @(negedge clk); restart = 1'b0; tick = 1'b0;
    idle(4);
    check_val("rs_tick_dropped", valid_cnt - v0, 32'd0);
    m_addr = A_FIRST; m_half = 1'b0;
    play_tick("rs_b", 0, 1'b0);
    play_tick("rs_c", 0, 1'b0);

    // 5: paused ticks ignored; ticks while busy dropped; in-flight fetch completes
    pause = 1'b1;
    v0 = valid_cnt; a0 = acc_cnt;
    for (int i = 0; i < 10; i++) pulse_tick();
    idle(6);
    check_val("t5_pause_reads", acc_cnt - a0, 32'd0);
    check_val("t5_pause_valid", valid_cnt - v0, 32'd0);
    pause = 1'b0;
    lat_cfg = 6;
    play_tick("t5_busy_a", 3, 1'b0);
    play_tick("t5_busy_b", 0, 1'b0);
    play_tick("t5_inflight_a", 0, 1'b1);
    play_tick("t5_inflight_b", 0, 1'b0);

    // 6: reset during WAIT_DATA, late readdatavalid ignored
    play_tick("t6_pre_a", 0, 1'b0);
    play_tick("t6_pre_b", 0, 1'b0);
    lat_cfg = 8;
    exp_addr.push_back(m_addr);
    pulse_tick();
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_addr = A_FIRST; m_half = 1'b0;
    v0 = valid_cnt;
    idle(12);
    check_val("t6_audio_zero", {24'h0, audio}, 32'h0);
    check_val("t6_no_valid", valid_cnt - v0, 32'd0);
    check_val("t6_addr_first", {9'h0, bus.flash_mem_address}, {9'h0, A_FIRST});
    check_val("t6_read_low", {31'b0, bus.flash_mem_read}, 32'h0);
    lat_cfg = 2;
    play_tick("t6_post_a", 0, 1'b0);
    play_tick("t6_post_b", 0, 1'b0);

    idle(5);
    check_val("audio_queue_empty", exp_audio.size(), 32'd0);
    check_val("addr_queue_empty", exp_addr.size(), 32'd0);
    check_val("total_pulses", valid_cnt, exp_pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
